memory_access_unit: RTL and testbench

- Initiator-side load/store unit that drives the cache client interface (enable/address/data_in/write_enable_bytes/busy/data_out/data_out_ready) on behalf of the RISC-V core.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned cache accesses with byte enables.
- Sign/zero-extends load results.
- Rejects misaligned or illegal accesses without touching the cache.

---
 rtl/mau_pkg.sv | 42 ++++
 rtl/mau_load_extract.sv | 27 ++
 rtl/memory_access_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_memory_access_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: RV32I funct3 codes,
// FSM state encoding, byte-lane constants and request legality helper.
package mau_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'd0;
    localparam logic [2:0] FUNCT3_H  = 3'd1;
    localparam logic [2:0] FUNCT3_W  = 3'd2;
    localparam logic [2:0] FUNCT3_BU = 3'd4;
    localparam logic [2:0] FUNCT3_HU = 3'd5;

    localparam int LANE_BITS = 8;
    localparam int NUM_LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_WAIT_BUSY     = 3'd1,
        ST_ISSUE         = 3'd2,
        ST_WAIT_READ     = 3'd3,
        ST_WAIT_BUSY_END = 3'd4,
        ST_WAIT_WRITE    = 3'd5,
        ST_RESPOND       = 3'd6
    } mau_state_e;

    // A request is rejected for an unknown width code, a store with an
    // unsigned-load code, or an address not aligned to the access size.
    function automatic logic req_is_error(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] low_addr);
        logic err;
        case (funct3)
            FUNCT3_B, FUNCT3_BU: err = 1'b0;
            FUNCT3_H, FUNCT3_HU: err = low_addr[0];
            FUNCT3_W:            err = (low_addr != 2'b00);
            default:             err = 1'b1;
        endcase
        if (write && (funct3 > FUNCT3_W)) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/mau_load_extract.sv
// Load data extraction: shifts the addressed byte/half to lane 0 and
// applies sign or zero extension according to funct3.
module mau_load_extract
    import mau_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  shift_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted_s;

    // Align the selected lane to bit 0, then extend to the full word.
    always_comb begin
        shifted_s = word_i >> {shift_i, 3'b000};
        case (funct3_i)
            FUNCT3_B:  data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            FUNCT3_BU: data_o = {24'h000000, shifted_s[7:0]};
            FUNCT3_H:  data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            FUNCT3_HU: data_o = {16'h0000, shifted_s[15:0]};
            FUNCT3_W:  data_o = shifted_s;
            default:   data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Load/store unit translating RV32I byte/half/word requests into
// word-aligned cache accesses with byte enables.
// Optional build macro: MEMORY_ACCESS_UNIT_STATS_EN adds outcome counters
// (stat_loads, stat_stores, stat_errors).
module memory_access_unit
    import mau_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_BITWIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [2:0]                  req_funct3,
    input  logic [ADDRESS_BITWIDTH-1:0] req_address,
    input  logic [DATA_BITWIDTH-1:0]    req_wr_data,
    output logic                        resp_valid,
    output logic [DATA_BITWIDTH-1:0]    resp_data,
    output logic                        resp_error,
    output logic                        c_enable,
    output logic [ADDRESS_BITWIDTH-1:0] c_address,
    output logic [DATA_BITWIDTH-1:0]    c_data_in,
    output logic [NUM_LANES-1:0]        c_write_enable_bytes,
    input  logic [DATA_BITWIDTH-1:0]    c_data_out,
    input  logic                        c_data_out_ready,
    input  logic                        c_busy
`ifdef MEMORY_ACCESS_UNIT_STATS_EN
    ,
    output logic [31:0]                 stat_loads,
    output logic [31:0]                 stat_stores,
    output logic [31:0]                 stat_errors
`endif
);

    mau_state_e state_q, state_d;

    logic                        write_q,  write_d;
    logic [2:0]                  funct3_q, funct3_d;
    logic [ADDRESS_BITWIDTH-1:0] addr_q,   addr_d;
    logic [DATA_BITWIDTH-1:0]    wdata_q,  wdata_d;
    logic                        error_q,  error_d;
    logic [DATA_BITWIDTH-1:0]    rdata_q,  rdata_d;
    logic [ADDRESS_BITWIDTH-1:0] caddr_q,  caddr_d;
    logic [DATA_BITWIDTH-1:0]    cdin_q,   cdin_d;
    logic [NUM_LANES-1:0]        cweb_q,   cweb_d;

    logic [DATA_BITWIDTH-1:0]    load_ext_s;
    logic [NUM_LANES-1:0]        store_web_s;
    logic [DATA_BITWIDTH-1:0]    store_din_s;

    mau_load_extract u_load_extract (
        .word_i   (c_data_out),
        .shift_i  (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_ext_s)
    );

    // Store lane encoding: replicate the low byte/half across lanes and
    // enable only the lanes addressed by the low address bits.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                store_web_s = 4'b0001 << addr_q[1:0];
                store_din_s = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                store_web_s = 4'b0011 << addr_q[1:0];
                store_din_s = {2{wdata_q[15:0]}};
            end
            default: begin
                store_web_s = 4'b1111;
                store_din_s = wdata_q;
            end
        endcase
    end

    // Next-state and datapath-register update logic of the transaction FSM.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        error_d  = error_q;
        rdata_d  = rdata_q;
        caddr_d  = caddr_q;
        cdin_d   = cdin_q;
        cweb_d   = cweb_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_address;
                    wdata_d  = req_wr_data;
                    rdata_d  = '0;
                    if (req_is_error(req_write, req_funct3, req_address[1:0])) begin
                        error_d = 1'b1;
                        state_d = ST_RESPOND;
                    end else begin
                        error_d = 1'b0;
                        state_d = ST_WAIT_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                if (!c_busy) begin
                    caddr_d = {addr_q[ADDRESS_BITWIDTH-1:2], 2'b00};
                    if (write_q) begin
                        cdin_d = store_din_s;
                        cweb_d = store_web_s;
                    end else begin
                        cdin_d = '0;
                        cweb_d = 4'b0000;
                    end
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_ISSUE: begin
                if (write_q) begin
                    state_d = ST_WAIT_WRITE;
                end else begin
                    state_d = ST_WAIT_READ;
                end
            end
            ST_WAIT_READ: begin
                // Data may arrive while a line fill is still in progress;
                // keep the result and wait for the cache to go idle.
                if (c_data_out_ready) begin
                    rdata_d = load_ext_s;
                    if (!c_busy) begin
                        state_d = ST_RESPOND;
                    end else begin
                        state_d = ST_WAIT_BUSY_END;
                    end
                end else begin
                    state_d = ST_WAIT_READ;
                end
            end
            ST_WAIT_BUSY_END: begin
                if (!c_busy) begin
                    state_d = ST_RESPOND;
                end else begin
                    state_d = ST_WAIT_BUSY_END;
                end
            end
            ST_WAIT_WRITE: begin
                if (!c_busy) begin
                    state_d = ST_RESPOND;
                end else begin
                    state_d = ST_WAIT_WRITE;
                end
            end
            ST_RESPOND: begin
                error_d = 1'b0;
                rdata_d = '0;
                caddr_d = '0;
                cdin_d  = '0;
                cweb_d  = 4'b0000;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request/cache-side registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
            caddr_q  <= '0;
            cdin_q   <= '0;
            cweb_q   <= 4'b0000;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            error_q  <= error_d;
            rdata_q  <= rdata_d;
            caddr_q  <= caddr_d;
            cdin_q   <= cdin_d;
            cweb_q   <= cweb_d;
        end
    end

    assign req_ready            = (state_q == ST_IDLE);
    assign c_enable             = (state_q == ST_ISSUE);
    assign resp_valid           = (state_q == ST_RESPOND);
    assign resp_data            = resp_valid ? rdata_q : '0;
    assign resp_error           = resp_valid & error_q;
    assign c_address            = caddr_q;
    assign c_data_in            = cdin_q;
    assign c_write_enable_bytes = cweb_q;

`ifdef MEMORY_ACCESS_UNIT_STATS_EN
    logic [31:0] stat_loads_q, stat_stores_q, stat_errors_q;

    // Outcome counters, bumped once per completed request; wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_loads_q  <= 32'd0;
            stat_stores_q <= 32'd0;
            stat_errors_q <= 32'd0;
        end else if (state_q == ST_RESPOND) begin
            if (error_q) begin
                stat_errors_q <= stat_errors_q + 32'd1;
            end else if (write_q) begin
                stat_stores_q <= stat_stores_q + 32'd1;
            end else begin
                stat_loads_q  <= stat_loads_q + 32'd1;
            end
        end else begin
            stat_loads_q  <= stat_loads_q;
            stat_stores_q <= stat_stores_q;
            stat_errors_q <= stat_errors_q;
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: a byte-array memory model
// stands in for the cache and provides expected load/store results.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_address = 32'd0;
    logic [31:0] req_wr_data = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        c_enable;
    logic [31:0] c_address;
    logic [31:0] c_data_in;
    logic [3:0]  c_write_enable_bytes;
    logic [31:0] c_data_out = 32'd0;
    logic        c_data_out_ready = 1'b0;
    logic        c_busy = 1'b0;
`ifdef MEMORY_ACCESS_UNIT_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_errors;
`endif

    memory_access_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_write            (req_write),
        .req_funct3           (req_funct3),
        .req_address          (req_address),
        .req_wr_data          (req_wr_data),
        .resp_valid           (resp_valid),
        .resp_data            (resp_data),
        .resp_error           (resp_error),
        .c_enable             (c_enable),
        .c_address            (c_address),
        .c_data_in            (c_data_in),
        .c_write_enable_bytes (c_write_enable_bytes),
        .c_data_out           (c_data_out),
        .c_data_out_ready     (c_data_out_ready),
        .c_busy               (c_busy)
`ifdef MEMORY_ACCESS_UNIT_STATS_EN
        ,
        .stat_loads           (stat_loads),
        .stat_stores          (stat_stores),
        .stat_errors          (stat_errors)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:63];
    int          total = 0;
    int          pass_cnt = 0;
    int          n_loads = 0, n_stores = 0, n_errors = 0;
    logic [31:0] last_data;
    logic        last_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int b;
        b = int'({a[5:2], 2'b00});
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    // One request with a scripted cache: pre = busy cycles before issue,
    // lat = cycles from enable to read data, post = extra busy after data,
    // wbusy = busy cycles after a store enable, junk = extra req_valid noise.
    task automatic xact(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int pre, input int lat,
                        input int post, input int wbusy, input bit junk);
        int          size;
        bit          sgn, err, bad_ready;
        logic [31:0] exp_load, exp_din, v;
        logic [3:0]  exp_web;
        int          e, r, enables, e_exp, r_exp;
        size = 0; sgn = 1'b0; err = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b0; end
            3'd4: begin size = 1; sgn = 1'b0; end
            3'd5: begin size = 2; sgn = 1'b0; end
            default: err = 1'b1;
        endcase
        if (wr && f3 > 3'd2) err = 1'b1;
        if (size == 2 && addr[0]) err = 1'b1;
        if (size == 4 && addr[1:0] != 2'b00) err = 1'b1;
        v = 32'd0; exp_web = 4'b0000;
        if (!err) begin
            for (int i = 0; i < size; i++) begin
                v = v | (32'(mem[int'(addr[5:0]) + i]) << (8 * i));
                exp_web[int'(addr[1:0]) + i] = 1'b1;
            end
            if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        end
        exp_load = v;
        exp_din = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;

        @(negedge clk);
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3;
        req_address = addr; req_wr_data = wd;
        c_busy = (pre > 0); c_data_out_ready = 1'b0;
        e = -1; r = -1; enables = 0; bad_ready = 1'b0;
        for (int k = 1; k <= 200 && r < 0; k++) begin
            @(negedge clk);
            if (req_ready !== 1'b0) bad_ready = 1'b1;
            if (c_enable === 1'b1) begin
                enables++;
                if (e < 0) begin
                    e = k;
                    check("c_address", c_address, {addr[31:2], 2'b00});
                    check("c_web", {28'd0, c_write_enable_bytes}, wr ? {28'd0, exp_web} : 32'd0);
                    if (wr) check("c_data_in", c_data_in, exp_din);
                end
            end
            if (resp_valid === 1'b1) begin
                r = k;
                last_data = resp_data; last_err = resp_error;
                check("resp_error", {31'd0, resp_error}, {31'd0, err});
                check("resp_data", resp_data, (err || wr) ? 32'd0 : exp_load);
            end
            req_valid   = (r < 0 && junk) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_write   = 1'($urandom_range(0, 1));
            req_funct3  = 3'($urandom_range(0, 7));
            req_address = $urandom;
            req_wr_data = $urandom;
            if (e < 0)   c_busy = (k < pre);
            else if (wr) c_busy = (k > e && k <= e + wbusy);
            else         c_busy = (k > e && k < e + lat + post);
            c_data_out_ready = (!wr && e >= 0 && k == e + lat);
            c_data_out = c_data_out_ready ? mem_word(addr) : $urandom;
        end
        req_valid = 1'b0; c_busy = 1'b0; c_data_out_ready = 1'b0;
        if (r < 0) begin
            check("resp_timeout", 32'd0, 32'd1);
        end else begin
            e_exp = (pre + 1 > 2) ? pre + 1 : 2;
            r_exp = err ? 1 : (wr ? e_exp + wbusy + 2 : e_exp + lat + post + 1);
            check("resp_cycle", r, r_exp);
            check("enable_count", enables, err ? 0 : 1);
            if (!err) check("enable_cycle", e, e_exp);
            check("ready_low_while_busy", {31'd0, bad_ready}, 32'd0);
            if (err) n_errors++; else if (wr) n_stores++; else n_loads++;
            if (wr && !err)
                for (int i = 0; i < size; i++) mem[int'(addr[5:0]) + i] = wd[8*i +: 8];
        end
        @(negedge clk);
        check("ready_after_resp", {30'd0, req_ready, resp_valid}, 32'd2);
    endtask

    initial begin
        bit seen, bad;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h80; mem[1] = 8'hA9; mem[2] = 8'hC6; mem[3] = 8'hB7;

        #2 rst = 1'b1;
        #1;
        check("rst_outputs", {resp_valid, resp_error, c_enable, c_write_enable_bytes}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_addr_data", c_address | c_data_in | resp_data, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed loads on the known word.
        xact(1'b0, 3'd0, 32'd0, 32'd0, 0, 1, 1, 0, 1'b0);
        check("lb0_const", last_data, 32'hFFFF_FF80);
        xact(1'b0, 3'd4, 32'd1, 32'd0, 0, 1, 0, 0, 1'b0);
        check("lbu1_const", last_data, 32'h0000_00A9);
        xact(1'b0, 3'd1, 32'd2, 32'd0, 0, 1, 0, 0, 1'b0);
        check("lh2_const", last_data, 32'hFFFF_B7C6);
        xact(1'b0, 3'd5, 32'd2, 32'd0, 0, 2, 0, 0, 1'b0);
        check("lhu2_const", last_data, 32'h0000_B7C6);
        // Byte store then word reload.
        xact(1'b1, 3'd0, 32'd1, 32'h1234_5678, 0, 1, 0, 1, 1'b0);
        xact(1'b0, 3'd2, 32'd0, 32'd0, 0, 1, 0, 0, 1'b0);
        check("lw0_after_sb", last_data, 32'hB7C6_7880);
        // Misaligned and illegal requests.
        xact(1'b0, 3'd2, 32'd2, 32'd0, 0, 1, 0, 0, 1'b0);
        check("lw2_err", {31'd0, last_err}, 32'd1);
        xact(1'b1, 3'd1, 32'd3, 32'hAAAA_5555, 0, 1, 0, 0, 1'b0);
        xact(1'b0, 3'd3, 32'd4, 32'd0, 0, 1, 0, 0, 1'b0);
        xact(1'b1, 3'd4, 32'd4, 32'd0, 0, 1, 0, 0, 1'b0);
        // Cache busy before issue, with extra request noise.
        xact(1'b0, 3'd2, 32'd8, 32'd0, 4, 2, 2, 0, 1'b1);
        xact(1'b1, 3'd2, 32'd12, 32'hCAFE_F00D, 3, 1, 0, 2, 1'b1);

        // Reset while waiting for read data.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_address = 32'd4;
        @(negedge clk);
        req_valid = 1'b0; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (c_enable === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("rst_test_enable", {31'd0, seen}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {resp_valid, resp_error, c_enable, c_write_enable_bytes}, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_addr_data", c_address | c_data_in | resp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0; bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        check("no_resp_after_rst", {31'd0, bad}, 32'd0);
`ifdef MEMORY_ACCESS_UNIT_STATS_EN
        n_loads = 0; n_stores = 0; n_errors = 0;
`endif
        xact(1'b0, 3'd2, 32'd0, 32'd0, 0, 1, 0, 0, 1'b0);
        check("lw0_after_rst", last_data, 32'hB7C6_7880);

        // Randomised traffic against the byte-array model.
        for (int t = 0; t < 40; t++) begin
            xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 32'($urandom_range(0, 63)), $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end

`ifdef MEMORY_ACCESS_UNIT_STATS_EN
        check("stat_loads", stat_loads, n_loads);
        check("stat_stores", stat_stores, n_stores);
        check("stat_errors", stat_errors, n_errors);
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
